// File: rtl/instr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer_pkg
// Description : Shared definitions for the instruction sequencer: opcode
//               constants, FSM state encoding and instruction field
//               bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_sequencer_pkg;

  // Opcodes (IR[15:12]); 7..14 execute as NOP
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  // Instruction field bit positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;
  localparam int JT_MSB  = 7;
  localparam int JT_LSB  = 0;

  // Opcodes whose result is written back through the ALU path
  function automatic logic is_alu_op(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_decoder
// Description : Purely combinational decode of a 16-bit instruction word into
//               register/immediate fields and datapath select signals.
// Revision    : 1.0 - initial release
// Ports       :
//   ir             in  16  instruction register
//   opcode         out 4   IR[15:12]
//   rd/rs1/rs2     out 3   IR[11:9] / IR[8:6] / IR[5:3]
//   imm            out 6   IR[5:0]
//   jmp_target     out 8   IR[7:0]
//   src2_select    out 1   immediate as ALU operand 2 (ADDI)
//   alu_out_select out 1   write-back from ALU (opcodes 0-4)
//   reg_write_en   out 1   instruction writes the register file
//   is_beq/is_jmp/is_halt out 1  control-flow class flags
// ============================================================================
module instr_decoder
  import instr_sequencer_pkg::*;
(
  input  logic [15:0] ir,
  output logic [3:0]  opcode,
  output logic [2:0]  rd,
  output logic [2:0]  rs1,
  output logic [2:0]  rs2,
  output logic [5:0]  imm,
  output logic [7:0]  jmp_target,
  output logic        src2_select,
  output logic        alu_out_select,
  output logic        reg_write_en,
  output logic        is_beq,
  output logic        is_jmp,
  output logic        is_halt
);

  logic [3:0] w_op;

  assign w_op           = ir[OPC_MSB:OPC_LSB];
  assign opcode         = w_op;
  assign rd             = ir[RD_MSB:RD_LSB];
  assign rs1            = ir[RS1_MSB:RS1_LSB];
  assign rs2            = ir[RS2_MSB:RS2_LSB];
  assign imm            = ir[IMM_MSB:IMM_LSB];
  assign jmp_target     = ir[JT_MSB:JT_LSB];
  assign src2_select    = (w_op == OP_ADDI);
  assign alu_out_select = is_alu_op(w_op);
  assign reg_write_en   = is_alu_op(w_op);
  assign is_beq         = (w_op == OP_BEQ);
  assign is_jmp         = (w_op == OP_JMP);
  assign is_halt        = (w_op == OP_HALT);

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Multi-cycle FETCH/DECODE/EXEC/WB control sequencer for the
//               16-bit core. Fetches over a req/ready handshake, decodes the
//               instruction, drives datapath controls and owns the PC.
// Revision    : 1.0 - initial release
// Ports       :
//   clk, rst                 clock / async active-high reset
//   imem_req/addr/ready/rdata instruction memory handshake
//   alu_zero                 ALU zero flag (BEQ condition)
//   instr_addr               current PC
//   pc_select, jump_addr     PC redirect control (valid in WB only)
//   src2_select, alu_out_select, reg_write  datapath controls
//   imm, rs1, rs2, rd, opcode decoded fields (valid DECODE..WB)
//   halted                   core stopped by HALT
// ============================================================================
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int              ADDR_W   = 8,
  parameter int              INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               alu_zero,
  output logic [ADDR_W-1:0]  instr_addr,
  output logic               pc_select,
  output logic [ADDR_W-1:0]  jump_addr,
  output logic               src2_select,
  output logic               alu_out_select,
  output logic               reg_write,
  output logic [5:0]         imm,
  output logic [2:0]         rs1,
  output logic [2:0]         rs2,
  output logic [2:0]         rd,
  output logic [3:0]         opcode,
  output logic               halted
);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic                r_imem_req;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic                r_fields_valid;
  logic                r_reg_write;
  logic                r_pc_select;
  logic [ADDR_W-1:0]   r_jump_addr;
  logic                r_halted;

  logic [3:0]          w_opcode;
  logic [2:0]          w_rd;
  logic [2:0]          w_rs1;
  logic [2:0]          w_rs2;
  logic [5:0]          w_imm;
  logic [7:0]          w_jmp_target;
  logic                w_src2_select;
  logic                w_alu_out_select;
  logic                w_reg_write_en;
  logic                w_is_beq;
  logic                w_is_jmp;
  logic                w_is_halt;
  logic [ADDR_W-1:0]   w_pc_plus1;
  logic [ADDR_W-1:0]   w_branch_target;
  logic [ADDR_W-1:0]   w_pc_next;

  instr_decoder u_decoder (
    .ir             (r_ir),
    .opcode         (w_opcode),
    .rd             (w_rd),
    .rs1            (w_rs1),
    .rs2            (w_rs2),
    .imm            (w_imm),
    .jmp_target     (w_jmp_target),
    .src2_select    (w_src2_select),
    .alu_out_select (w_alu_out_select),
    .reg_write_en   (w_reg_write_en),
    .is_beq         (w_is_beq),
    .is_jmp         (w_is_jmp),
    .is_halt        (w_is_halt)
  );

  // PC arithmetic wraps naturally at ADDR_W bits
  assign w_pc_plus1      = r_pc + ADDR_W'(1);
  assign w_branch_target = w_pc_plus1 + {{(ADDR_W-6){w_imm[5]}}, w_imm};
  assign w_pc_next       = r_pc_select ? r_jump_addr : w_pc_plus1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_FETCH;
      r_pc           <= RESET_PC;
      r_ir           <= '0;
      r_imem_req     <= 1'b0;
      r_imem_addr    <= '0;
      r_fields_valid <= 1'b0;
      r_reg_write    <= 1'b0;
      r_pc_select    <= 1'b0;
      r_jump_addr    <= '0;
      r_halted       <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          // A grant only counts once the request is actually visible;
          // the first cycle after reset raises the request.
          if (r_imem_req && imem_ready) begin
            r_ir           <= imem_rdata;
            r_imem_req     <= 1'b0;
            r_fields_valid <= 1'b1;
            r_state        <= S_DECODE;
          end else begin
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_pc;
          end
        end
        S_DECODE: begin
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_is_halt) begin
            r_halted       <= 1'b1;
            r_fields_valid <= 1'b0;
            r_state        <= S_HALT;
          end else begin
            r_reg_write <= w_reg_write_en;
            // alu_zero is sampled here, at the end of EXEC; the
            // registered pc_select doubles as the branch-taken flag.
            if (w_is_jmp) begin
              r_pc_select <= 1'b1;
              r_jump_addr <= ADDR_W'(w_jmp_target);
            end else if (w_is_beq && alu_zero) begin
              r_pc_select <= 1'b1;
              r_jump_addr <= w_branch_target;
            end
            r_state <= S_WB;
          end
        end
        S_WB: begin
          r_pc           <= w_pc_next;
          r_imem_addr    <= w_pc_next;
          r_imem_req     <= 1'b1;
          r_reg_write    <= 1'b0;
          r_pc_select    <= 1'b0;
          r_jump_addr    <= '0;
          r_fields_valid <= 1'b0;
          r_state        <= S_FETCH;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

  assign imem_req       = r_imem_req;
  assign imem_addr      = r_imem_addr;
  assign instr_addr     = r_pc;
  assign pc_select      = r_pc_select;
  assign jump_addr      = r_jump_addr;
  assign reg_write      = r_reg_write;
  assign halted         = r_halted;

  // Fields and selects are held at zero outside DECODE..WB so a cleared IR
  // (which decodes as ADD) never leaks control activity.
  assign opcode         = r_fields_valid ? w_opcode         : 4'd0;
  assign rd             = r_fields_valid ? w_rd             : 3'd0;
  assign rs1            = r_fields_valid ? w_rs1            : 3'd0;
  assign rs2            = r_fields_valid ? w_rs2            : 3'd0;
  assign imm            = r_fields_valid ? w_imm            : 6'd0;
  assign src2_select    = r_fields_valid & w_src2_select;
  assign alu_out_select = r_fields_valid & w_alu_out_select;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Directed self-checking bench for instr_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic        alu_zero;
  logic [7:0]  instr_addr;
  logic        pc_select;
  logic [7:0]  jump_addr;
  logic        src2_select;
  logic        alu_out_select;
  logic        reg_write;
  logic [5:0]  imm;
  logic [2:0]  rs1, rs2, rd;
  logic [3:0]  opcode;
  logic        halted;

  logic [15:0] mem [256];
  int checks   = 0;
  int failures = 0;

  assign imem_rdata = mem[imem_addr];

  always #5 clk = ~clk;

  instr_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .alu_zero       (alu_zero),
    .instr_addr     (instr_addr),
    .pc_select      (pc_select),
    .jump_addr      (jump_addr),
    .src2_select    (src2_select),
    .alu_out_select (alu_out_select),
    .reg_write      (reg_write),
    .imm            (imm),
    .rs1            (rs1),
    .rs2            (rs2),
    .rd             (rd),
    .opcode         (opcode),
    .halted         (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h7000;  // NOP
    mem[8'h00] = 16'h0298;  // ADD r1,r2,r3
    mem[8'h01] = 16'h4405;  // ADDI r2,r0,#5
    mem[8'h02] = 16'h6010;  // JMP 0x10
    mem[8'h10] = 16'h503E;  // BEQ imm=-2
    mem[8'h11] = 16'h60FF;  // JMP 0xFF
    rst = 1'b1; imem_ready = 1'b1; alu_zero = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_regwr", reg_write, 0);
    chk("rst_aluout", alu_out_select, 0);
    chk("rst_halted", halted, 0);
    chk("rst_pcsel", pc_select, 0);
    rst = 1'b0;

    // ADD r1,r2,r3 at address 0
    tick();
    chk("add_fetch_req", imem_req, 1);
    chk("add_fetch_addr", imem_addr, 8'h00);
    tick();
    chk("add_opcode", opcode, 0);
    chk("add_rd", rd, 1);
    chk("add_rs1", rs1, 2);
    chk("add_rs2", rs2, 3);
    chk("add_aluout", alu_out_select, 1);
    chk("add_src2", src2_select, 0);
    chk("add_req_low", imem_req, 0);
    tick();
    chk("add_exec_regwr", reg_write, 0);
    tick();
    chk("add_wb_regwr", reg_write, 1);
    chk("add_wb_pcsel", pc_select, 0);
    tick();
    chk("next_fetch_addr", imem_addr, 8'h01);
    chk("regwr_one_cycle", reg_write, 0);

    // ADDI r2,r0,#5
    tick();
    chk("addi_src2", src2_select, 1);
    chk("addi_imm", imm, 5);
    chk("addi_aluout", alu_out_select, 1);
    chk("addi_rd", rd, 2);
    tick(); tick();
    chk("addi_wb_regwr", reg_write, 1);
    tick();
    chk("addi_next_addr", imem_addr, 8'h02);

    // JMP 0x10
    tick(); tick(); tick();
    chk("jmp_pcsel", pc_select, 1);
    chk("jmp_addr", jump_addr, 8'h10);
    chk("jmp_regwr", reg_write, 0);
    tick();
    chk("jmp_fetch_addr", imem_addr, 8'h10);
    chk("jmp_pcsel_off", pc_select, 0);
    chk("jmp_jaddr_off", jump_addr, 0);

    // BEQ at 0x10, taken
    alu_zero = 1'b1;
    tick(); tick(); tick();
    chk("beq_t_pcsel", pc_select, 1);
    chk("beq_t_jaddr", jump_addr, 8'h0F);
    tick();
    chk("beq_t_fetch", imem_addr, 8'h0F);
    alu_zero = 1'b0;

    // NOP at 0x0F, then BEQ at 0x10 not taken
    tick(); tick(); tick();
    chk("nop_regwr", reg_write, 0);
    tick();
    chk("nop_fetch", imem_addr, 8'h10);
    tick(); tick(); tick();
    chk("beq_nt_pcsel", pc_select, 0);
    tick();
    chk("beq_nt_fetch", imem_addr, 8'h11);

    // JMP 0xFF, then NOP at 0xFF wraps to 0x00
    tick(); tick(); tick(); tick();
    chk("jmp_ff_fetch", imem_addr, 8'hFF);
    tick(); tick(); tick(); tick();
    chk("wrap_fetch", imem_addr, 8'h00);
    chk("wrap_pc", instr_addr, 8'h00);

    // Three wait cycles: request and address held
    mem[8'h01] = 16'hF000;  // HALT on the next visit
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, 8'h00);
    end
    imem_ready = 1'b1;
    tick();
    chk("wait_decode_op", opcode, 0);
    chk("wait_decode_rd", rd, 1);
    tick(); tick();
    chk("wait_wb_regwr", reg_write, 1);
    tick();
    chk("wait_next_fetch", imem_addr, 8'h01);

    // HALT
    tick(); tick(); tick();
    chk("halt_halted", halted, 1);
    chk("halt_req", imem_req, 0);
    chk("halt_regwr", reg_write, 0);
    repeat (5) tick();
    chk("halt_stays", halted, 1);
    chk("halt_req_stays", imem_req, 0);

    // Reset, then async reset again in the middle of a fetch
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem_ready = 1'b0;
    tick();
    chk("rerun_req", imem_req, 1);
    chk("rerun_halted", halted, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_req", imem_req, 0);
    chk("async_rst_halted", halted, 0);
    #2;
    rst = 1'b0;
    imem_ready = 1'b1;
    tick();
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 8'h00);
    tick();
    chk("restart_rd", rd, 1);
    chk("restart_aluout", alu_out_select, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle control sequencer for the 16-bit custom processor. Fetches 16-bit instructions from instruction memory over a req/ready handshake and decodes the fields. Sequences the datapath through FETCH/DECODE/EXEC/WB, driving the same select, write-enable and field signals the control logic provides. Owns the PC, including branch/jump redirection and halt.

Parameters:
ADDR_W, 8, PC / instruction address width
INSTR_W, 16, instruction width
RESET_PC, 8'h00, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request, held until accepted
imem_addr  out  ADDR_W  fetch address (= PC)
imem_ready  in  1  memory accepts request; imem_rdata valid this cycle
imem_rdata  in  INSTR_W  fetched instruction
alu_zero  in  1  ALU zero flag from the datapath
instr_addr  out  ADDR_W  current PC
pc_select  out  1  1 = PC loads jump_addr; 0 = PC+1
jump_addr  out  ADDR_W  redirect target
src2_select  out  1  1 = ALU operand 2 is immediate
alu_out_select  out  1  1 = write-back from ALU; 0 = pass operand 2
reg_write  out  1  register-file write strobe
imm  out  6  immediate field IR[5:0]
rs1, rs2, rd  out  3 each  register addresses IR[8:6], IR[5:3], IR[11:9]
opcode  out  4  IR[15:12]
halted  out  1  core halted

Behaviour:
- Reset (async, any state, mid-handshake included):
  - state=FETCH, PC=RESET_PC, IR=16'h0000.
  - All outputs 0, except imem_req=1 and imem_addr=RESET_PC one cycle after rst falls.
  - A pending request is abandoned without a grant.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR: R-type.
  - 4 ADDI.
  - 5 BEQ: rs1 vs rs2 via ALU SUB; taken if alu_zero.
  - 6 JMP: target IR[7:0].
  - 15 HALT.
  - 7-14: NOP.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - On imem_ready: IR <= imem_rdata, go to DECODE.
  - Otherwise stay; address stays stable.
- DECODE (1 cycle):
  - opcode/rs1/rs2/rd/imm driven from IR; they stay stable through WB.
  - src2_select=1 for ADDI.
  - alu_out_select=1 for opcodes 0-4.
- EXEC (1 cycle):
  - BEQ samples alu_zero at the end of EXEC into a taken flag.
  - HALT goes to HALT state; PC does not advance.
- WB (1 cycle):
  - reg_write=1 for opcodes 0-4 only, exactly one cycle per instruction.
  - Next PC:
    - JMP: pc_select=1, jump_addr=IR[7:0].
    - BEQ taken: pc_select=1, jump_addr=PC+1+sext(imm).
    - Otherwise: pc_select=0, PC+1.
  - All PC arithmetic is mod 2^ADDR_W: 8'hFF+1 = 8'h00; backward branches wrap.
  - PC updates at the WB clock edge, then FETCH.
- HALT: halted=1, imem_req=0, reg_write=0. Exit only by reset.
- Timing:
  - Zero-wait memory: 4 cycles per instruction.
  - Each cycle imem_ready stays low adds 1 cycle.
  - imem_ready outside FETCH is ignored.
- Unused outputs: pc_select and jump_addr are 0 outside WB.

Decomposition:
- Shared package holds:
  - opcode constants (OP_ADD..OP_HALT).
  - state encoding (S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT).
  - field bit positions.
- One natural sub-module: instr_decoder (combinational IR -> field and select signals), reused by the sequencer.

Test Plan:
- Reset with imem_ready=1 and memory {0x0000 ADD r1,r2,r3}: fetch at addr 0. reg_write pulses in cycle 4 with rd=1, rs1=2, rs2=3. Next fetch at addr 1.
- ADDI r2,r0,#5 (0x4405): src2_select=1, imm=6'd5, alu_out_select=1, reg_write for 1 cycle.
- JMP 0x40 (0x6040): pc_select=1 and jump_addr=8'h40 in WB. Next imem_addr=8'h40. reg_write stays 0.
- BEQ at PC=8'h10, imm=6'h3E (-2):
  - alu_zero=1: next fetch at 8'h0F.
  - alu_zero=0: next fetch at 8'h11.
- PC=8'hFF with NOP: next fetch at 8'h00. Then hold imem_ready=0 for 3 cycles: imem_req and addr stay stable, instruction takes 7 cycles.
- HALT (0xF000): halted=1, imem_req=0 permanently. Assert rst mid-FETCH of a later run: outputs clear immediately, fetch restarts at RESET_PC.
